dmem_ctrl: RTL and testbench

DMEM_CTRL -- requirements
Module: dmem_ctrl

---
 rtl/dmem_pkg.sv | 29 ++
 rtl/dmem_lane.sv | 30 +++
 rtl/dmem_ctrl.sv | 119 +++++++++++
 tb/tb_dmem_ctrl.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types for the data-memory controller: FSM states, store-width codes,
// wait-counter width and the misalignment predicate.
package dmem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    MW_NONE = 2'b00,
    MW_WORD = 2'b01,
    MW_HALF = 2'b10,
    MW_BYTE = 2'b11
  } mw_t;

  localparam int CNT_W = 8;

  // MW_NONE with a live request is a word load, so it aligns like a word.
  function automatic logic is_misaligned(input mw_t mw, input logic [1:0] addr_lo);
    case (mw)
      MW_NONE, MW_WORD: return addr_lo != 2'b00;
      MW_HALF:          return addr_lo[0];
      default:          return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lane.sv
// Byte-lane steering: access width and low address bits select the byte
// enables, and store data is replicated across lanes.
module dmem_lane
  import dmem_pkg::*;
(
  input  logic [1:0]  mw,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] data,
  output logic [3:0]  be,
  output logic [31:0] wdata
);

  // NOTE: every output gets a default first so no path through the case infers a latch.
  always_comb begin
    be    = 4'b1111;
    wdata = data;
    case (mw_t'(mw))
      MW_HALF: begin
        be    = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata = {2{data[15:0]}};
      end
      MW_BYTE: begin
        be    = 4'b0001 << addr_lo;
        wdata = {4{data[7:0]}};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: turns datapath load/store requests into a stalling
// bus transaction with timeout. DMEM_MISALIGN_TRAP_EN enables the misalign trap.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  mem_w,
  input  logic        mem_r,
  input  logic [31:0] Addr_in,
  input  logic [31:0] Data_in,
  output logic [31:0] Rdata_out,
  output logic        stall,
  output logic        err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  state_t           state, state_next;
  logic [CNT_W-1:0] wait_cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic             is_load_q;
  logic             request, is_store, timeout, misalign;
  logic [3:0]       lane_be;
  logic [31:0]      lane_wdata;

  assign is_store = mem_w != MW_NONE;
  assign request  = is_store || mem_r;
  assign cnt_inc  = wait_cnt + 1'b1;
  assign timeout  = cnt_inc == CNT_W'(TIMEOUT_CYCLES);

`ifdef DMEM_MISALIGN_TRAP_EN
  assign misalign = is_misaligned(mw_t'(mem_w), Addr_in[1:0]);
`else
  assign misalign = 1'b0;
`endif

  dmem_lane u_lane (
    .mw      (mem_w),
    .addr_lo (Addr_in[1:0]),
    .data    (Data_in),
    .be      (lane_be),
    .wdata   (lane_wdata)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (request) state_next = misalign ? ST_DONE : ST_BUSY;
      ST_BUSY: if (bus_ack || timeout) state_next = ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
    stall = reset && ((state == ST_IDLE && request) || state == ST_BUSY);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wait_cnt  <= '0;
      is_load_q <= 1'b0;
      err       <= 1'b0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_be    <= '0;
      bus_wdata <= '0;
      Rdata_out <= '0;
    end else begin
      err <= 1'b0;
      case (state)
        ST_IDLE: if (request) begin
          is_load_q <= !is_store;
          wait_cnt  <= '0;
          if (misalign) begin
            err <= 1'b1;
            if (!is_store) Rdata_out <= '0;
          end else begin
            bus_req   <= 1'b1;
            bus_we    <= is_store;
            bus_addr  <= {Addr_in[31:2], 2'b00};
            bus_be    <= lane_be;
            bus_wdata <= lane_wdata;
          end
        end
        ST_BUSY: begin
          // Ack takes priority over a timeout landing in the same cycle.
          if (bus_ack) begin
            bus_req <= 1'b0;
            bus_we  <= 1'b0;
            if (is_load_q) Rdata_out <= bus_rdata;
          end else begin
            wait_cnt <= cnt_inc;
            if (timeout) begin
              bus_req <= 1'b0;
              bus_we  <= 1'b0;
              err     <= 1'b1;
              if (is_load_q) Rdata_out <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed self-checking bench for dmem_ctrl (TIMEOUT_CYCLES = 4); covers the
// DMEM_MISALIGN_TRAP_EN build when that macro is defined.
module tb_dmem_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  mem_w;
  logic        mem_r;
  logic [31:0] Addr_in, Data_in, Rdata_out, bus_addr, bus_wdata, bus_rdata;
  logic        stall, err, bus_req, bus_we, bus_ack;
  logic [3:0]  bus_be;

  int tests  = 0;
  int failed = 0;

  // Results of the most recent run_txn call.
  int          r_stalls, r_req_cycles;
  logic        r_done, r_we, r_err, r_req_done, r_err_after, r_req_after;
  logic [3:0]  r_be;
  logic [31:0] r_addr, r_wdata, r_rdata, r_rdata_after;

  dmem_ctrl #(.TIMEOUT_CYCLES(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .mem_w     (mem_w),
    .mem_r     (mem_r),
    .Addr_in   (Addr_in),
    .Data_in   (Data_in),
    .Rdata_out (Rdata_out),
    .stall     (stall),
    .err       (err),
    .bus_req   (bus_req),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_be    (bus_be),
    .bus_wdata (bus_wdata),
    .bus_ack   (bus_ack),
    .bus_rdata (bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issues one request in IDLE and follows it to DONE; ack_at is the BUSY
  // cycle (1-based) in which bus_ack is asserted, 0 for never.
  task automatic run_txn(input logic [1:0] mw, input logic mr, input logic [31:0] addr,
                         input logic [31:0] data, input int ack_at, input logic [31:0] rdata,
                         input logic hold_req);
    r_stalls = 0; r_req_cycles = 0; r_done = 1'b0;
    r_be = 'x; r_addr = 'x; r_wdata = 'x; r_we = 1'bx;
    mem_w = mw; mem_r = mr; Addr_in = addr; Data_in = data;
    bus_ack = 1'b0; bus_rdata = rdata;
    #1;
    if (stall) r_stalls++;
    for (int i = 1; i <= 40 && !r_done; i++) begin
      step();
      bus_ack = 1'b0;
      if (!stall) begin
        r_done = 1'b1; r_err = err; r_rdata = Rdata_out; r_req_done = bus_req;
        if (!hold_req) begin mem_w = 2'b00; mem_r = 1'b0; end
      end else begin
        r_stalls++;
        if (bus_req) r_req_cycles++;
        if (i == 1) begin r_be = bus_be; r_addr = bus_addr; r_wdata = bus_wdata; r_we = bus_we; end
        if (i == ack_at) bus_ack = 1'b1;
      end
    end
    step();
    r_err_after = err; r_rdata_after = Rdata_out; r_req_after = bus_req;
    mem_w = 2'b00; mem_r = 1'b0;
    step();
  endtask

  task automatic test_reset();
    reset = 1'b0; mem_w = 2'b00; mem_r = 1'b1; Addr_in = 32'h0; Data_in = 32'h0;
    bus_ack = 1'b0; bus_rdata = 32'h0;
    step(); step();
    tests++; if ({bus_req, bus_we, bus_be, bus_addr, bus_wdata, Rdata_out, err} !== '0) begin
      failed++; $display("FAIL reset_outputs: req=%b we=%b be=%h addr=%h wdata=%h rdata=%h err=%b, want all 0",
                         bus_req, bus_we, bus_be, bus_addr, bus_wdata, Rdata_out, err); end
    tests++; if (stall !== 1'b0) begin failed++; $display("FAIL reset_stall: got %b want 0", stall); end
    mem_r = 1'b0; reset = 1'b1;
    step();
  endtask

  task automatic test_store_word();
    run_txn(2'b01, 1'b0, 32'h0000_0104, 32'hDEAD_BEEF, 3, 32'h0, 1'b0);
    tests++; if (r_done !== 1'b1) begin failed++; $display("FAIL sw_done: got %b want 1", r_done); end
    tests++; if (r_stalls != 4) begin failed++; $display("FAIL sw_stall_cycles: got %0d want 4", r_stalls); end
    tests++; if (r_req_cycles != 3) begin failed++; $display("FAIL sw_req_cycles: got %0d want 3", r_req_cycles); end
    tests++; if ({r_we, r_be} !== 5'b1_1111) begin failed++; $display("FAIL sw_we_be: got %b want 11111", {r_we, r_be}); end
    tests++; if (r_addr !== 32'h0000_0104) begin failed++; $display("FAIL sw_addr: got %h want 00000104", r_addr); end
    tests++; if (r_wdata !== 32'hDEAD_BEEF) begin failed++; $display("FAIL sw_wdata: got %h want deadbeef", r_wdata); end
    tests++; if ({r_err, r_req_done} !== 2'b00) begin failed++; $display("FAIL sw_done_err_req: got %b want 00", {r_err, r_req_done}); end
  endtask

  task automatic test_store_byte_half();
    run_txn(2'b11, 1'b0, 32'h0000_0203, 32'h0000_00A5, 1, 32'h0, 1'b0);
    tests++; if (r_be !== 4'b1000) begin failed++; $display("FAIL sb_be: got %b want 1000", r_be); end
    tests++; if (r_wdata !== 32'hA5A5_A5A5) begin failed++; $display("FAIL sb_wdata: got %h want a5a5a5a5", r_wdata); end
    tests++; if (r_addr !== 32'h0000_0200) begin failed++; $display("FAIL sb_addr: got %h want 00000200", r_addr); end
    tests++; if (r_stalls != 2) begin failed++; $display("FAIL sb_stall_cycles: got %0d want 2", r_stalls); end
    run_txn(2'b10, 1'b0, 32'h0000_0302, 32'h1234_BEEF, 1, 32'h0, 1'b0);
    tests++; if ({r_be, r_wdata} !== {4'b1100, 32'hBEEF_BEEF}) begin
      failed++; $display("FAIL sh_upper: got be=%b wdata=%h want be=1100 wdata=beefbeef", r_be, r_wdata); end
  endtask

  task automatic test_misalign();
    run_txn(2'b10, 1'b0, 32'h0000_0011, 32'h0000_C0DE, 1, 32'h0, 1'b0);
`ifdef DMEM_MISALIGN_TRAP_EN
    tests++; if (r_req_cycles != 0) begin failed++; $display("FAIL mis_no_req: got %0d req cycles want 0", r_req_cycles); end
    tests++; if (r_stalls != 1) begin failed++; $display("FAIL mis_stall: got %0d want 1", r_stalls); end
    tests++; if ({r_err, r_err_after} !== 2'b10) begin failed++; $display("FAIL mis_err_pulse: got %b want 10", {r_err, r_err_after}); end
`else
    tests++; if ({r_be, r_addr} !== {4'b0011, 32'h0000_0010}) begin
      failed++; $display("FAIL sh_lower: got be=%b addr=%h want be=0011 addr=00000010", r_be, r_addr); end
    tests++; if ({r_wdata, r_err} !== {32'hC0DE_C0DE, 1'b0}) begin
      failed++; $display("FAIL sh_lower_data: got wdata=%h err=%b want c0dec0de 0", r_wdata, r_err); end
`endif
  endtask

  task automatic test_load();
    run_txn(2'b00, 1'b1, 32'h0000_0040, 32'h0, 2, 32'h1234_5678, 1'b0);
    tests++; if ({r_we, r_be} !== 5'b0_1111) begin failed++; $display("FAIL lw_we_be: got %b want 01111", {r_we, r_be}); end
    tests++; if (r_rdata !== 32'h1234_5678) begin failed++; $display("FAIL lw_rdata: got %h want 12345678", r_rdata); end
    tests++; if (Rdata_out !== 32'h1234_5678) begin failed++; $display("FAIL lw_hold: got %h want 12345678", Rdata_out); end
  endtask

  task automatic test_store_over_load();
    run_txn(2'b01, 1'b1, 32'h0000_0048, 32'h0000_0055, 1, 32'hFFFF_FFFF, 1'b0);
    tests++; if (r_we !== 1'b1) begin failed++; $display("FAIL swlw_we: got %b want 1", r_we); end
    tests++; if (r_rdata !== 32'h1234_5678) begin failed++; $display("FAIL swlw_rdata: got %h want 12345678", r_rdata); end
  endtask

  task automatic test_ack_outside_busy();
    bus_ack = 1'b1; bus_rdata = 32'hCAFE_F00D;
    step(); step();
    tests++; if ({Rdata_out, bus_req, stall} !== {32'h1234_5678, 2'b00}) begin
      failed++; $display("FAIL stray_ack: got rdata=%h req=%b stall=%b want 12345678 0 0", Rdata_out, bus_req, stall); end
    bus_ack = 1'b0;
    step();
  endtask

  task automatic test_timeout();
    run_txn(2'b00, 1'b1, 32'h0000_0080, 32'h0, 0, 32'h0, 1'b0);
    tests++; if (r_req_cycles != 4) begin failed++; $display("FAIL to_req_cycles: got %0d want 4", r_req_cycles); end
    tests++; if (r_stalls != 5) begin failed++; $display("FAIL to_stall: got %0d want 5", r_stalls); end
    tests++; if ({r_err, r_err_after, r_req_done} !== 3'b100) begin failed++; $display("FAIL to_err_pulse: got %b want 100", {r_err, r_err_after, r_req_done}); end
    tests++; if (r_rdata !== 32'h0) begin failed++; $display("FAIL to_rdata: got %h want 00000000", r_rdata); end
    run_txn(2'b00, 1'b1, 32'h0000_0044, 32'h0, 4, 32'h0BAD_F00D, 1'b0);
    tests++; if ({r_err, r_rdata} !== {1'b0, 32'h0BAD_F00D}) begin
      failed++; $display("FAIL ack_at_timeout: got err=%b rdata=%h want 0 0badf00d", r_err, r_rdata); end
  endtask

  task automatic test_reset_mid();
    mem_w = 2'b00; mem_r = 1'b1; Addr_in = 32'h0000_0090;
    step();
    tests++; if (bus_req !== 1'b1) begin failed++; $display("FAIL rst_mid_busy: got req=%b want 1", bus_req); end
    reset = 1'b0;
    #1;
    tests++; if (stall !== 1'b0) begin failed++; $display("FAIL rst_mid_stall_low: got %b want 0", stall); end
    step();
    tests++; if ({bus_req, err, stall} !== 3'b000) begin failed++; $display("FAIL rst_mid_edge: got %b want 000", {bus_req, err, stall}); end
    reset = 1'b1; mem_r = 1'b0;
    step();
    tests++; if ({bus_req, err, stall} !== 3'b000) begin failed++; $display("FAIL rst_mid_after: got %b want 000", {bus_req, err, stall}); end
  endtask

  task automatic test_no_reissue();
    run_txn(2'b00, 1'b1, 32'h0000_00A0, 32'h0, 1, 32'h7777_0001, 1'b1);
    tests++; if ({r_done, r_req_after} !== 2'b10) begin failed++; $display("FAIL no_reissue: got done/req=%b want 10", {r_done, r_req_after}); end
    tests++; if (r_rdata_after !== 32'h7777_0001) begin failed++; $display("FAIL post_reset_load: got %h want 77770001", r_rdata_after); end
  endtask

  initial begin
    test_reset();
    test_store_word();
    test_store_byte_half();
    test_misalign();
    test_load();
    test_store_over_load();
    test_ack_outside_busy();
    test_timeout();
    test_reset_mid();
    test_no_reissue();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
